// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the CPU machine-cycle sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned PHASES_MIN = 2;
    localparam int unsigned PHASES_MAX = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2,
        HALTED    = 2'd3
    } state_e;

endpackage

// File: rtl/cpu_phase_seq_phase_decoder.sv
// Phase index to one-hot phase enables, all zero when not running.
module phase_decoder #(
    parameter  int unsigned PHASES = 8,
    localparam int unsigned PW     = $clog2(PHASES)
) (
    input  logic              i_run,
    input  logic [PW-1:0]     i_phase,
    output logic [PHASES-1:0] o_phase_oh
);

    always_comb begin
        o_phase_oh = '0;
        for (int unsigned i = 0; i < PHASES; i++) begin
            o_phase_oh[i] = i_run && (i_phase == PW'(i));
        end
    end

endmodule

// File: rtl/cpu_phase_seq.sv
// Machine-cycle sequencer: phase counter, graceful halt, single-step,
// restart after halt and a retired-cycle counter.
module cpu_phase_seq
    import cpu_ctrl_pkg::*;
#(
    parameter  int unsigned PHASES = 8,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned PW     = $clog2(PHASES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch,
    input  logic              halt,
    input  logic              step_mode,
    input  logic              step_req,
    output logic              run,
    output logic [PW-1:0]     phase,
    output logic [PHASES-1:0] phase_oh,
    output logic              cycle_start,
    output logic              cycle_end,
    output logic              halted,
    output logic [CNT_W-1:0]  cyc_count
);

    if (PHASES < PHASES_MIN || PHASES > PHASES_MAX) begin : g_bad_phases
        $error("cpu_phase_seq: PHASES out of range");
    end

    localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [PW-1:0]    r_phase;
    logic [PW-1:0]    w_phase_nxt;
    logic             r_halt_pend;
    logic             w_halt_pend_nxt;
    logic [CNT_W-1:0] r_cyc_count;
    logic [CNT_W-1:0] w_cyc_count_nxt;
    logic             w_run;
    logic             w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_halt_pend <= 1'b0;
            r_cyc_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            r_cyc_count <= w_cyc_count_nxt;
        end
    end

    assign w_run  = (r_state == RUN);
    assign w_last = (r_phase == LAST_PHASE);

    // Phase is forced to 0 on every exit from RUN, so it reads 0 when idle.
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_halt_pend_nxt = r_halt_pend;
        w_cyc_count_nxt = r_cyc_count;
        case (r_state)
            IDLE, HALTED: begin
                if (fetch && !halt) begin
                    w_state_nxt = RUN;
                    w_phase_nxt = '0;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_cyc_count_nxt = r_cyc_count + CNT_W'(1);
                    w_phase_nxt     = '0;
                    if (r_halt_pend || halt) begin
                        w_state_nxt     = HALTED;
                        w_halt_pend_nxt = 1'b0;
                    end else if (step_mode) begin
                        w_state_nxt = STEP_WAIT;
                    end
                end else begin
                    w_phase_nxt     = r_phase + PW'(1);
                    w_halt_pend_nxt = r_halt_pend | halt;
                end
            end
            STEP_WAIT: begin
                if (halt) begin
                    w_state_nxt = HALTED;
                end else if (step_req || !step_mode) begin
                    w_state_nxt = RUN;
                    w_phase_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    phase_decoder #(
        .PHASES (PHASES)
    ) u_phase_decoder (
        .i_run      (w_run),
        .i_phase    (r_phase),
        .o_phase_oh (phase_oh)
    );

    assign run         = w_run;
    assign phase       = r_phase;
    assign cycle_start = w_run && (r_phase == '0);
    assign cycle_end   = w_run && w_last;
    assign halted      = (r_state == HALTED);
    assign cyc_count   = r_cyc_count;

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Bench for cpu_phase_seq: two instances (8 phases/16-bit count and
// 2 phases/4-bit count) driven in parallel against a behavioural model.
module tb_cpu_phase_seq;

    localparam int unsigned P0 = 8;
    localparam int unsigned W0 = 16;
    localparam int unsigned P1 = 2;
    localparam int unsigned W1 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fetch = 1'b0;
    logic halt = 1'b0;
    logic step_mode = 1'b0;
    logic step_req = 1'b0;

    logic          run0, cycle_start0, cycle_end0, halted0;
    logic [2:0]    phase0;
    logic [7:0]    phase_oh0;
    logic [15:0]   cyc_count0;
    logic          run1, cycle_start1, cycle_end1, halted1;
    logic [0:0]    phase1;
    logic [1:0]    phase_oh1;
    logic [3:0]    cyc_count1;

    always #5 clk = ~clk;

    cpu_phase_seq #(.PHASES(P0), .CNT_W(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .fetch(fetch), .halt(halt),
        .step_mode(step_mode), .step_req(step_req),
        .run(run0), .phase(phase0), .phase_oh(phase_oh0),
        .cycle_start(cycle_start0), .cycle_end(cycle_end0),
        .halted(halted0), .cyc_count(cyc_count0)
    );

    cpu_phase_seq #(.PHASES(P1), .CNT_W(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .fetch(fetch), .halt(halt),
        .step_mode(step_mode), .step_req(step_req),
        .run(run1), .phase(phase1), .phase_oh(phase_oh1),
        .cycle_start(cycle_start1), .cycle_end(cycle_end1),
        .halted(halted1), .cyc_count(cyc_count1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: per instance, a "running" / "waiting for step" / "halted" view.
    int np[2] = '{P0, P1};
    int nw[2] = '{W0, W1};
    int m_run[2];
    int m_wait[2];
    int m_hlt[2];
    int m_ph[2];
    int m_pend[2];
    int m_cnt[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_wait[k] = 0; m_hlt[k] = 0;
            m_ph[k] = 0; m_pend[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            if (m_run[k] != 0) begin
                if (halt) m_pend[k] = 1;
                if (m_ph[k] == np[k] - 1) begin
                    m_cnt[k] = (m_cnt[k] + 1) % (1 << nw[k]);
                    m_ph[k]  = 0;
                    if (m_pend[k] != 0) begin
                        m_run[k] = 0; m_hlt[k] = 1; m_pend[k] = 0;
                    end else if (step_mode) begin
                        m_run[k] = 0; m_wait[k] = 1;
                    end
                end else begin
                    m_ph[k]++;
                end
            end else if (m_wait[k] != 0) begin
                if (halt) begin
                    m_wait[k] = 0; m_hlt[k] = 1;
                end else if (step_req || !step_mode) begin
                    m_wait[k] = 0; m_run[k] = 1; m_ph[k] = 0;
                end
            end else if (fetch && !halt) begin
                m_run[k] = 1; m_hlt[k] = 0; m_ph[k] = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_oh(input int k);
        return (m_run[k] != 0) ? (32'd1 << m_ph[k]) : 32'd0;
    endfunction

    task automatic check_all();
        chk("run0",    32'(run0),         32'(m_run[0]));
        chk("phase0",  32'(phase0),       32'(m_ph[0]));
        chk("oh0",     32'(phase_oh0),    exp_oh(0));
        chk("cstart0", 32'(cycle_start0), 32'(m_run[0] != 0 && m_ph[0] == 0));
        chk("cend0",   32'(cycle_end0),   32'(m_run[0] != 0 && m_ph[0] == P0 - 1));
        chk("halted0", 32'(halted0),      32'(m_hlt[0]));
        chk("count0",  32'(cyc_count0),   32'(m_cnt[0]));
        chk("run1",    32'(run1),         32'(m_run[1]));
        chk("phase1",  32'(phase1),       32'(m_ph[1]));
        chk("oh1",     32'(phase_oh1),    exp_oh(1));
        chk("cstart1", 32'(cycle_start1), 32'(m_run[1] != 0 && m_ph[1] == 0));
        chk("cend1",   32'(cycle_end1),   32'(m_run[1] != 0 && m_ph[1] == P1 - 1));
        chk("halted1", 32'(halted1),      32'(m_hlt[1]));
        chk("count1",  32'(cyc_count1),   32'(m_cnt[1]));
    endtask

    // One clock edge: model advances with the inputs held, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_phase0(input int ph, input string tag);
        int i = 0;
        while (!(run0 && phase0 == 3'(ph)) && i < 64) begin
            tick();
            i++;
        end
        chk(tag, 32'(run0 && phase0 == 3'(ph)), 32'd1);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_run0", 32'(run0), 32'd0);
        chk("rst_phase0", 32'(phase0), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        model_reset();
        #2;
        check_all();
        tick();
        rst_n = 1'b1;
        tick();

        // Halt wins over fetch in IDLE
        fetch = 1'b1; halt = 1'b1;
        tick();
        chk("idle_halt_wins", 32'(run0), 32'd0);
        halt = 1'b0;
        tick();
        chk("start_run", 32'(run0), 32'd1);
        chk("start_phase", 32'(phase0), 32'd0);
        fetch = 1'b0;
        repeat (7) tick();
        chk("cend_at_7", 32'(cycle_end0), 32'd1);
        tick();
        chk("count_is_1", 32'(cyc_count0), 32'd1);
        repeat (8) tick();
        chk("count_is_2", 32'(cyc_count0), 32'd2);
        repeat (16) tick();
        chk("count4_wrap", 32'(cyc_count1), 32'd0);
        chk("count_is_4", 32'(cyc_count0), 32'd4);

        // Graceful halt mid-cycle
        wait_phase0(3, "reach_ph3");
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_no_trunc", 32'(run0), 32'd1);
        repeat (4) tick();
        chk("halted_after_end", 32'(halted0), 32'd1);
        repeat (3) tick();
        chk("halt_cnt_held", 32'(cyc_count0), 32'd5);
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        chk("restart_phase", 32'(phase0), 32'd0);
        chk("restart_cnt", 32'(cyc_count0), 32'd5);

        // Single-step
        step_mode = 1'b1;
        n = 0;
        while (run0 && n < 20) begin tick(); n++; end
        chk("enter_step_wait", 32'(run0 == 1'b0 && halted0 == 1'b0), 32'd1);
        repeat (2) tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        n = 0;
        while (run0 && n < 20) begin
            n++;
            step_req = (n == 3);
            tick();
        end
        step_req = 1'b0;
        chk("step_len", 32'(n), 32'd8);
        chk("step_cnt", 32'(cyc_count0), 32'd7);

        // Halt beats step_req in STEP_WAIT
        halt = 1'b1; step_req = 1'b1;
        tick();
        halt = 1'b0; step_req = 1'b0;
        chk("step_halt_wins", 32'(halted0), 32'd1);

        // Async reset mid-cycle
        step_mode = 1'b0;
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        wait_phase0(5, "reach_ph5");
        async_reset();
        tick();
        chk("idle_after_rst", 32'(run0), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            fetch    = ($urandom_range(7) == 0);
            halt     = ($urandom_range(23) == 0);
            step_req = ($urandom_range(3) == 0);
            if ($urandom_range(31) == 0) step_mode = ~step_mode;
            if (i == 1500) async_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
